aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the iterative AES-128 core. It drives the registered round-step units (SubBytes, Shift_Rows, MixColumns, AddRoundKey) through their one-cycle `en` → `done` handshake in standard round order. It tracks the round number and issues the round-key index to the key store. It sits between the top-level block interface (`start`/`done`) and the step datapath, and owns all step enables and the operand-source select.

## Interface
- `NR`, 10: number of rounds; the final round omits MixColumns.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin one block; sampled only in IDLE.
- `abort` in 1: synchronous cancel; return to IDLE, no `done`.
- `sb_done`, `sr_done`, `mc_done`, `ark_done` in 1 each: step-unit done pulses.
- `sb_en`, `sr_en`, `mc_en`, `ark_en` out 1 each: one-cycle step enable pulses.
- `src_sel` out 2: operand source for the active step: 0 input block, 1 SB out, 2 SR out, 3 MC out.
- `round` out 4: current round, 0..NR.
- `key_idx` out 4: round-key index for AddRoundKey.
- `busy` out 1: block in progress.
- `done` out 1: one-cycle pulse, block complete.
- `proto_err` out 1: sticky flag; a step done arrived that was not expected.

## Operation
- States: IDLE, ISSUE, WAIT, FIN. Stage register holds SB, SR, MC, or ARK.
- IDLE + `start`: `round` ← 0, stage ← ARK, `key_idx` ← 0, go to ISSUE.
- ISSUE: assert the current stage's `en` for exactly one cycle, then go to WAIT.
- WAIT: hold until the matching `*_done` is sampled high, then advance:
  - ARK with `round` < NR: `round`++, stage ← SB, go to ISSUE.
  - ARK with `round` = NR: go to FIN.
  - SB → SR.
  - SR → MC if `round` < NR, else ARK.
  - MC → ARK.
- `key_idx` = `round` during ARK.
- `src_sel` per stage:
  - ARK0: 0.
  - SB: 0 in round 1, else 3 for the previous ARK result held in the MC slot. Datapath muxes the ARK output there.
  - SR: 1.
  - MC: 2.
  - ARK: 3 when round < NR, 2 when round = NR.
- FIN: `done`=1 for one cycle, go to IDLE.
- Non-matching or unexpected `*_done` (wrong stage, or in IDLE/ISSUE/FIN): ignored for sequencing; sets `proto_err`. Cleared only by `rst` or by `start` accepted in IDLE.
- `start` while not IDLE: ignored.
- `abort` in any non-IDLE state: next state IDLE, all enables low, no `done`. `abort` has priority over `done` advance in the same cycle.
- Reset mid-block: immediate IDLE, all outputs at reset value.

## Timing
- Reset values:
  - State IDLE.
  - `round`=0, `key_idx`=0, `src_sel`=0.
  - All `*_en`=0, `busy`=0, `done`=0, `proto_err`=0.
- Outputs are registered. `busy`=1 from the cycle after `start` through the final WAIT cycle.
- Each stage takes 2 cycles with standard units: `en` at cycle t, `done` at t+1, next `en` at t+2.
- NR=10, start accepted at cycle 0:
  - ark_en for key 0 at cycle 1.
  - Final ark_done at cycle 80.
  - `done` at cycle 81 with `busy`=0.
  - Total: 81 cycles start-to-done.
- Step done delayed k extra cycles: latency grows by exactly k; no timeout.

## Configuration
- `AES_DECRYPT_EN` defined: adds input `decrypt` (1 bit, latched at `start`) and output `inv` (= latched `decrypt`).
  - Decrypt order: ARK(key NR).
  - Rounds NR-1..1: SR, SB, ARK, MC (inverse units via `inv`).
  - Final: SR, SB, ARK(key 0).
  - `key_idx` = NR − `round`. Cycle count is identical to encrypt.
- Undefined: encrypt only; no `decrypt`/`inv` ports.

## Structure
- Shared package `aes_pkg`:
  - State enum.
  - Stage enum (SB, SR, MC, ARK).
  - `src_sel` codes.
  - `AES128_NR`=10.
- One sub-module, `aes_round_counter`: round/key-index counter with load, increment, and direction (direction used only with `AES_DECRYPT_EN`).

## Test plan
- Reset during WAIT of round 5 → all outputs at reset values immediately. A fresh `start` afterwards completes in 81 cycles.
- Single `start` with 1-cycle responders → `ark_en` at cycle 1, `done` at cycle 81. `mc_en` pulses 9 times; `sb_en`, `sr_en` 10 times; `ark_en` 11 times. `key_idx` sequence 0..10.
- Responder delays `sr_done` by 3 cycles in every round → `done` at cycle 111. `start` pulsed at cycle 40 is ignored.
- Inject `mc_done` while waiting for `sb_done` → `proto_err`=1, sequence unaffected. Next accepted `start` clears `proto_err`.
- `abort` asserted in the same cycle as `ark_done` of round 3 → IDLE next cycle, no `done`, `busy`=0.
- `AES_DECRYPT_EN`, `decrypt`=1 → first `ark_en` with `key_idx`=10. Order is SR, SB, ARK, MC; final `key_idx`=0; `done` at cycle 81.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
package aes_pkg;
    localparam int AES128_NR = 10;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIN} state_t;
    typedef enum logic [1:0] {STG_SB, STG_SR, STG_MC, STG_ARK} stage_t;

    localparam logic [1:0] SRC_IN = 2'd0;
    localparam logic [1:0] SRC_SB = 2'd1;
    localparam logic [1:0] SRC_SR = 2'd2;
    localparam logic [1:0] SRC_MC = 2'd3;
endpackage

// File: rtl/aes_round_counter.sv
// Round number and round-key index counter; dir=1 counts the key index down from NR.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       inc,
    input  logic       dir,
    output logic [3:0] round,
    output logic [3:0] key_idx,
    output logic [3:0] round_nxt
);
    localparam logic [3:0] NR_L = 4'(NR);

    always_comb begin
        round_nxt = round;
        if (load)
            round_nxt = 4'd0;
        else if (inc)
            round_nxt = round + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round   <= 4'd0;
            key_idx <= 4'd0;
        end else if (load) begin
            round   <= 4'd0;
            key_idx <= dir ? NR_L : 4'd0;
        end else if (inc) begin
            round   <= round + 4'd1;
            key_idx <= dir ? key_idx - 4'd1 : key_idx + 4'd1;
        end
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer; defining AES_DECRYPT_EN adds the decrypt input and inv output.
// States: IDLE wait start | ISSUE pulse step en | WAIT await step done | FIN pulse done
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       sb_done,
    input  logic       sr_done,
    input  logic       mc_done,
    input  logic       ark_done,
`ifdef AES_DECRYPT_EN
    input  logic       decrypt,
    output logic       inv,
`endif
    output logic       sb_en,
    output logic       sr_en,
    output logic       mc_en,
    output logic       ark_en,
    output logic [1:0] src_sel,
    output logic [3:0] round,
    output logic [3:0] key_idx,
    output logic       busy,
    output logic       done,
    output logic       proto_err
);
    localparam logic [3:0] NR_L = 4'(NR);

    state_t     state, state_nxt;
    stage_t     stage, stage_nxt;
    logic       cnt_load, cnt_inc, cnt_dir, dec_mode;
    logic [3:0] round_nxt, done_vec, exp_mask;
    logic       match, unexpected;
    logic       sb_en_nxt, sr_en_nxt, mc_en_nxt, ark_en_nxt;
    logic       busy_nxt, done_nxt, perr_nxt;
    logic [1:0] src_nxt;

`ifdef AES_DECRYPT_EN
    logic inv_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inv_q <= 1'b0;
        else if (state == ST_IDLE && start)
            inv_q <= decrypt;
    end
    assign inv      = inv_q;
    assign dec_mode = inv_q;
    assign cnt_dir  = cnt_load ? decrypt : inv_q;
`else
    assign dec_mode = 1'b0;
    assign cnt_dir  = 1'b0;
`endif

    aes_round_counter #(.NR(NR)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .dir       (cnt_dir),
        .round     (round),
        .key_idx   (key_idx),
        .round_nxt (round_nxt)
    );

    // Bit positions follow the stage enum so the expected done is a simple shift.
    assign done_vec   = {ark_done, mc_done, sr_done, sb_done};
    assign exp_mask   = (state == ST_WAIT) ? (4'b0001 << stage) : 4'b0000;
    assign match      = |(done_vec & exp_mask);
    assign unexpected = |(done_vec & ~exp_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            stage <= STG_ARK;
        end else begin
            state <= state_nxt;
            stage <= stage_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_nxt = ST_ISSUE;
                stage_nxt = STG_ARK;
                cnt_load  = 1'b1;
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: if (match) begin
                state_nxt = ST_ISSUE;
                if (!dec_mode) begin
                    case (stage)
                        STG_ARK: if (round < NR_L) begin
                            cnt_inc   = 1'b1;
                            stage_nxt = STG_SB;
                        end else begin
                            state_nxt = ST_FIN;
                        end
                        STG_SB:  stage_nxt = STG_SR;
                        STG_SR:  stage_nxt = (round < NR_L) ? STG_MC : STG_ARK;
                        default: stage_nxt = STG_ARK;
                    endcase
                end else begin
                    case (stage)
                        STG_ARK: if (round == 4'd0) begin
                            cnt_inc   = 1'b1;
                            stage_nxt = STG_SR;
                        end else if (round < NR_L) begin
                            stage_nxt = STG_MC;
                        end else begin
                            state_nxt = ST_FIN;
                        end
                        STG_SR:  stage_nxt = STG_SB;
                        STG_SB:  stage_nxt = STG_ARK;
                        default: begin
                            cnt_inc   = 1'b1;
                            stage_nxt = STG_SR;
                        end
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            stage_nxt = stage;
            cnt_inc   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        sb_en_nxt  = (state_nxt == ST_ISSUE) && (stage_nxt == STG_SB);
        sr_en_nxt  = (state_nxt == ST_ISSUE) && (stage_nxt == STG_SR);
        mc_en_nxt  = (state_nxt == ST_ISSUE) && (stage_nxt == STG_MC);
        ark_en_nxt = (state_nxt == ST_ISSUE) && (stage_nxt == STG_ARK);
        busy_nxt   = (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT);
        done_nxt   = (state_nxt == ST_FIN);
        perr_nxt   = ((state == ST_IDLE && start) ? 1'b0 : proto_err) | unexpected;
        src_nxt    = SRC_IN;
        if (state_nxt != ST_IDLE) begin
            case (stage_nxt)
                STG_SB:  src_nxt = (round_nxt == 4'd1) ? SRC_IN : SRC_MC;
                STG_SR:  src_nxt = SRC_SB;
                STG_MC:  src_nxt = SRC_SR;
                default: src_nxt = (round_nxt == 4'd0) ? SRC_IN :
                                   (round_nxt < NR_L) ? SRC_MC : SRC_SR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_en     <= 1'b0;
            sr_en     <= 1'b0;
            mc_en     <= 1'b0;
            ark_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            proto_err <= 1'b0;
            src_sel   <= SRC_IN;
        end else begin
            sb_en     <= sb_en_nxt;
            sr_en     <= sr_en_nxt;
            mc_en     <= mc_en_nxt;
            ark_en    <= ark_en_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            proto_err <= perr_nxt;
            src_sel   <= src_nxt;
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: responder model plus expected round schedule.
module tb_aes_round_ctrl;
    localparam int NR = 10;
    localparam int S_SB = 0, S_SR = 1, S_MC = 2, S_ARK = 3;

    logic clk = 1'b0;
    logic rst, start, abort, sb_done, sr_done, mc_done, ark_done;
    logic sb_en, sr_en, mc_en, ark_en, busy, done, proto_err;
    logic [1:0] src_sel;
    logic [3:0] round, key_idx;
`ifdef AES_DECRYPT_EN
    logic decrypt, inv;
`endif

    int tests = 0;
    int fails = 0;

    aes_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .sb_done   (sb_done),
        .sr_done   (sr_done),
        .mc_done   (mc_done),
        .ark_done  (ark_done),
`ifdef AES_DECRYPT_EN
        .decrypt   (decrypt),
        .inv       (inv),
`endif
        .sb_en     (sb_en),
        .sr_en     (sr_en),
        .mc_en     (mc_en),
        .ark_en    (ark_en),
        .src_sel   (src_sel),
        .round     (round),
        .key_idx   (key_idx),
        .busy      (busy),
        .done      (done),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int en_count();
        return int'(sb_en) + int'(sr_en) + int'(mc_en) + int'(ark_en);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_en"}, en_count(), 0);
        chk({tag, "_src"}, src_sel, 0);
        chk({tag, "_round"}, round, 0);
        chk({tag, "_key"}, key_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_perr"}, proto_err, 0);
    endtask

    // One block: builds the expected stage schedule, then plays step-unit responder.
    task automatic run_block(input bit rnd, input int sr_d, input int start_cyc,
                             input int inj_idx, input int abort_idx, input int rst_idx,
                             input bit dec);
        int stg[$], key[$], src[$], del[$];
        int ens[4], exp_ens[4];
        int exp_done, cyc, idx, pending, n, d, es;
        bit finished, inj_arm, rst_arm;
        finished = 0; inj_arm = 0; rst_arm = 0; idx = 0; pending = 0;
        for (int k = 0; k < 4; k++) begin ens[k] = 0; exp_ens[k] = 0; end

        stg.push_back(S_ARK); key.push_back(dec ? NR : 0); src.push_back(dec ? -1 : 0);
        for (int r = 1; r <= NR; r++) begin
            if (!dec) begin
                stg.push_back(S_SB); key.push_back(-1); src.push_back(r == 1 ? 0 : 3);
                stg.push_back(S_SR); key.push_back(-1); src.push_back(1);
                if (r < NR) begin stg.push_back(S_MC); key.push_back(-1); src.push_back(2); end
                stg.push_back(S_ARK); key.push_back(r); src.push_back(r < NR ? 3 : 2);
            end else begin
                stg.push_back(S_SR); key.push_back(-1); src.push_back(-1);
                stg.push_back(S_SB); key.push_back(-1); src.push_back(-1);
                stg.push_back(S_ARK); key.push_back(NR - r); src.push_back(-1);
                if (r < NR) begin stg.push_back(S_MC); key.push_back(-1); src.push_back(-1); end
            end
        end
        exp_done = 1;
        foreach (stg[i]) begin
            d = rnd ? int'($urandom_range(0, 3)) : (stg[i] == S_SR ? sr_d : 0);
            if (i == inj_idx && d == 0) d = 1;
            if (i == rst_idx) d = 2;
            del.push_back(d);
            exp_ens[stg[i]]++;
            exp_done += 2 + d;
        end

`ifdef AES_DECRYPT_EN
        decrypt = dec;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk("proto_err_clr", proto_err, 0);

        while (!finished && cyc < 400) begin
            sb_done = 0; sr_done = 0; mc_done = 0; ark_done = 0; abort = 0;
            start = (cyc == start_cyc);
            if (inj_arm) begin mc_done = 1; inj_arm = 0; end
            if (rst_arm) begin
                #2 rst = 1'b1;
                #1 check_reset("rst_mid");
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    case (stg[idx-1])
                        S_SB:    sb_done = 1;
                        S_SR:    sr_done = 1;
                        S_MC:    mc_done = 1;
                        default: ark_done = 1;
                    endcase
                    if (idx - 1 == abort_idx) begin
                        abort = 1;
                        @(posedge clk); #1;
                        abort = 0; ark_done = 0;
                        repeat (5) begin
                            chk("abort_busy", busy, 0);
                            chk("abort_done", done, 0);
                            chk("abort_en", en_count(), 0);
                            @(posedge clk); #1;
                        end
                        break;
                    end
                end
            end
            n = en_count();
            if (done) begin
                chk("done_cycle", cyc, exp_done);
                chk("done_busy", busy, 0);
                chk("stages_issued", idx, stg.size());
                chk("sb_count", ens[S_SB], exp_ens[S_SB]);
                chk("sr_count", ens[S_SR], exp_ens[S_SR]);
                chk("mc_count", ens[S_MC], exp_ens[S_MC]);
                chk("ark_count", ens[S_ARK], exp_ens[S_ARK]);
                chk("proto_err", proto_err, inj_idx >= 0);
                finished = 1;
                @(posedge clk); #1;
                chk("done_pulse", done, 0);
            end else begin
                chk("busy", busy, 1);
                if (n != 0) begin
                    chk("en_onehot", n, 1);
                    es = ark_en ? S_ARK : mc_en ? S_MC : sr_en ? S_SR : S_SB;
                    if (idx < stg.size()) begin
                        chk("en_stage", es, stg[idx]);
                        if (stg[idx] == S_ARK) chk("key_idx", key_idx, key[idx]);
                        if (src[idx] >= 0) chk("src_sel", src_sel, src[idx]);
`ifdef AES_DECRYPT_EN
                        chk("inv", inv, dec);
`endif
                        ens[es]++;
                        pending = 1 + del[idx];
                        if (idx == inj_idx) inj_arm = 1;
                        if (idx == rst_idx) rst_arm = 1;
                        idx++;
                    end else begin
                        chk("extra_en", n, 0);
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!finished && cyc >= 400) chk("timeout", cyc, exp_done);
        sb_done = 0; sr_done = 0; mc_done = 0; ark_done = 0; abort = 0; start = 0;
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0;
        sb_done = 0; sr_done = 0; mc_done = 0; ark_done = 0;
`ifdef AES_DECRYPT_EN
        decrypt = 0;
`endif
        repeat (3) @(posedge clk);
        #1 check_reset("reset_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset("reset_idle");

        run_block(0, 0, -1, -1, -1, -1, 0);
        run_block(0, 3, 40, -1, -1, -1, 0);
        run_block(0, 0, -1, 5, -1, -1, 0);
        run_block(0, 0, -1, -1, -1, -1, 0);
        run_block(0, 0, -1, -1, 12, -1, 0);
        run_block(0, 0, -1, -1, -1, 18, 0);
        run_block(0, 0, -1, -1, -1, -1, 0);
        repeat (3) run_block(1, 0, -1, -1, -1, -1, 0);
`ifdef AES_DECRYPT_EN
        run_block(0, 0, -1, -1, -1, -1, 1);
        run_block(1, 0, -1, -1, -1, -1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
